// File: rtl/ccip_c1_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing the CCI-P C1 write channel between N_PORTS requesters.
// Optional per-port statistics counters are built when CCIP_ARB_STATS_EN is defined.
package ccip_c1_arb_pkg;
    typedef logic [511:0] t_ccip_clData;

    localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
    localparam logic [1:0] eCL_LEN_1     = 2'b00;
    localparam logic [1:0] eCL_LEN_2     = 2'b01;
    localparam logic [1:0] eCL_LEN_4     = 2'b11;

    typedef struct packed {
        logic [5:0]  rsvd2;
        logic [1:0]  vc_sel;
        logic        sop;
        logic        rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic               valid;
        t_ccip_clData       data;
    } t_if_ccip_c1_Tx;
endpackage

module ccip_c1_tx_arbiter
    import ccip_c1_arb_pkg::*;
#(
    parameter int N_PORTS  = 2,
    parameter int LN_PORTS = $clog2(N_PORTS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sRx_c1TxAlmFull,
    input  logic [N_PORTS-1:0]  req_valid,
    input  t_ccip_c1_ReqMemHdr  req_hdr  [N_PORTS],
    input  t_ccip_clData        req_data [N_PORTS],
    output logic [N_PORTS-1:0]  req_ready,
    output t_if_ccip_c1_Tx      sTx_c1,
    output logic [LN_PORTS-1:0] grant_idx,
    output logic                error
`ifdef CCIP_ARB_STATS_EN
    ,
    output logic [31:0]         stat_beats        [N_PORTS],
    output logic [31:0]         stat_stall_cycles [N_PORTS]
`endif
);

    typedef enum logic {ArbIdle, ArbBurst} t_arb_state;

    t_arb_state          state, state_next;
    logic [1:0]          beats_left, beats_left_next;
    logic [LN_PORTS-1:0] rr_ptr, rr_ptr_next, grant_next, sel;
    logic [LN_PORTS-1:0] first_idx, stray_idx;
    logic                first_hit, stray_hit;
    logic [N_PORTS-1:0]  first_cand, stray_cand;
    logic                fwd, error_set;

    // Returns {found, index} of the first candidate searching upward from ptr+1 with wrap.
    function automatic logic [LN_PORTS:0] rr_pick(input logic [N_PORTS-1:0] cand,
                                                  input logic [LN_PORTS-1:0] ptr);
        logic [LN_PORTS:0]   r;
        logic [LN_PORTS-1:0] i;
        int unsigned         idx;
        r = '0;
        for (int unsigned k = 32'(N_PORTS); k >= 1; k--) begin
            idx = (32'(ptr) + k) % 32'(N_PORTS);
            i   = LN_PORTS'(idx);
            if (cand[i]) r = {1'b1, i};
        end
        return r;
    endfunction

    // Non-sop beats only win in idle when no sop beat is eligible; they are then consumed as errors.
    always_comb begin
        first_cand = '0;
        stray_cand = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            first_cand[i] = req_valid[i] & req_hdr[i].sop & ~sRx_c1TxAlmFull;
            stray_cand[i] = req_valid[i] & ~req_hdr[i].sop & ~sRx_c1TxAlmFull;
        end
        {first_hit, first_idx} = rr_pick(first_cand, rr_ptr);
        {stray_hit, stray_idx} = rr_pick(stray_cand, rr_ptr);
    end

    always_comb begin
        state_next      = state;
        beats_left_next = beats_left;
        rr_ptr_next     = rr_ptr;
        grant_next      = grant_idx;
        sel             = grant_idx;
        req_ready       = '0;
        fwd             = 1'b0;
        error_set       = 1'b0;
        case (state)
            ArbIdle: begin
                if (first_hit) begin
                    sel            = first_idx;
                    req_ready[sel] = 1'b1;
                    if (req_hdr[sel].cl_len == 2'b10) begin
                        error_set = 1'b1;
                    end else begin
                        fwd             = 1'b1;
                        grant_next      = sel;
                        rr_ptr_next     = sel;
                        beats_left_next = req_hdr[sel].cl_len;
                        if (req_hdr[sel].cl_len != eCL_LEN_1) state_next = ArbBurst;
                    end
                end else if (stray_hit) begin
                    sel            = stray_idx;
                    req_ready[sel] = 1'b1;
                    error_set      = 1'b1;
                end
            end
            ArbBurst: begin
                req_ready[grant_idx] = 1'b1;
                if (req_valid[grant_idx]) begin
                    if (req_hdr[grant_idx].sop) begin
                        error_set = 1'b1;
                    end else begin
                        fwd             = 1'b1;
                        beats_left_next = beats_left - 2'd1;
                        if (beats_left == 2'd1) state_next = ArbIdle;
                    end
                end
            end
            default: state_next = ArbIdle;
        endcase
        if (!reset_n) begin
            req_ready = '0;
            fwd       = 1'b0;
            error_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ArbIdle;
            beats_left <= '0;
            rr_ptr     <= LN_PORTS'(N_PORTS - 1);
            grant_idx  <= '0;
            error      <= 1'b0;
            sTx_c1     <= '0;
        end else begin
            state        <= state_next;
            beats_left   <= beats_left_next;
            rr_ptr       <= rr_ptr_next;
            grant_idx    <= grant_next;
            error        <= error | error_set;
            sTx_c1.valid <= fwd;
            if (fwd) begin
                sTx_c1.hdr  <= req_hdr[sel];
                sTx_c1.data <= req_data[sel];
            end
        end
    end

`ifdef CCIP_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                stat_beats[i]        <= '0;
                stat_stall_cycles[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (req_valid[i] && req_ready[i] && stat_beats[i] != '1)
                    stat_beats[i] <= stat_beats[i] + 32'd1;
                if (req_valid[i] && !req_ready[i] && stat_stall_cycles[i] != '1)
                    stat_stall_cycles[i] <= stat_stall_cycles[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ccip_c1_tx_arbiter.md
# ccip_c1_tx_arbiter

Shares the CCI-P C1 (memory write) TX channel between `N_PORTS` requesters, such as co-located NIC instances or a NIC TX path plus a control/status writer. Each requester issues `eREQ_WRLINE_I` writes of 1, 2 or 4 cache lines. The block arbitrates round-robin at burst granularity, so a multi-line burst is never interleaved with another port's beats. It stops new bursts while the host raises C1 almost-full, and drives a single registered `sTx_c1` towards the CCI-P shim.

## Interface
Parameters:
- `N_PORTS`, 2: number of requesters, from 2 to 8.
- `LN_PORTS`, 1: `$clog2(N_PORTS)`, the width of the grant index.

Ports:
- `clk`  in  1  CCI-P clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sRx_c1TxAlmFull`  in  1  host C1 almost-full.
- `req_valid`  in  N_PORTS  per-port beat valid.
- `req_hdr`  in  N_PORTS x t_ccip_c1_ReqMemHdr  per-port beat header; `sop` and `cl_len` are meaningful on the first beat.
- `req_data`  in  N_PORTS x t_ccip_clData  per-port beat data.
- `req_ready`  out  N_PORTS  per-port accept; a beat transfers when valid and ready are both high.
- `sTx_c1`  out  t_if_ccip_c1_Tx  arbitrated C1 request.
- `grant_idx`  out  LN_PORTS  owner of the current or most recent burst.
- `error`  out  1  sticky protocol error.

## Operation
- FSM states:
  - `ArbIdle`: no burst in progress.
  - `ArbBurst`: port `grant_idx` owns the channel with `beats_left` > 0.
- In `ArbIdle`, a port is eligible when `req_valid[i] & req_hdr[i].sop` and `sRx_c1TxAlmFull == 0`.
  - The winner is the first eligible port searching upward, with wrap, from `rr_ptr + 1`.
  - `req_ready[winner]` goes high combinationally in the same cycle; every other `req_ready` stays low.
- On acceptance of a first beat:
  - Latch `grant_idx`.
  - Set `rr_ptr <= winner`.
  - Load `beats_left <= cl_len`, giving 0, 1 or 3 beats remaining. `cl_len` encoding: `eCL_LEN_1` = 0, `eCL_LEN_2` = 1, `eCL_LEN_4` = 3.
  - If `beats_left` is nonzero, go to `ArbBurst`; otherwise stay in `ArbIdle`, so a new grant is possible the next cycle.
- In `ArbBurst`:
  - `req_ready[grant_idx] = 1` regardless of almost-full. An already-granted burst always completes, relying on the CCI-P almost-full slack of at least 8 entries.
  - Each accepted beat decrements `beats_left`. The FSM returns to `ArbIdle` on the beat that takes `beats_left` from 1 to 0.
  - Valid gaps from the owner are allowed. The lock is held indefinitely with no timeout, and other ports keep waiting.
- Protocol errors:
  - Any of the following sets `error` (sticky until reset), and the offending beat is consumed and dropped:
    - a beat with `sop = 0` presented by the winning port in `ArbIdle`;
    - a beat with `sop = 1` from the owner in `ArbBurst`;
    - `cl_len == 2'b10` (illegal).
  - Consuming a dropped beat means `req_ready` is high for it but nothing is forwarded.
  - A dropped beat does not change the FSM, `rr_ptr` or `beats_left`.
- Output: each accepted, non-dropped beat is registered onto `sTx_c1`, with `valid = 1` and `hdr`/`data` passed through unmodified, on the next cycle.
  - On cycles with no accepted beat, `sTx_c1.valid <= 0`, and `hdr`/`data` hold their previous values.
- Reset values:
  - FSM state `ArbIdle`, `beats_left` 0, `rr_ptr` = N_PORTS-1 (port 0 has first priority).
  - `grant_idx` 0, `error` 0, `sTx_c1.valid` 0, `sTx_c1.hdr` 0.
  - `req_ready` is all zeros while `reset_n` is low.
- Reset mid-burst: the burst is abandoned and the next transfer must start with `sop = 1`. Requesters are reset in the same domain.

## Timing
- Acceptance to `sTx_c1.valid`: 1 cycle.
- Throughput: 1 beat per cycle, including back-to-back bursts from different ports with no idle cycle between them.
- `req_ready` depends combinationally on `req_valid`, `req_hdr.sop` and `sRx_c1TxAlmFull`. Requesters must not make `req_valid` depend on `req_ready`.
- Almost-full asserted on cycle T blocks first-beat grants on cycle T itself, because the input is not registered.
- A `reset_n` deassertion must be synchronous to `clk`; the synchroniser sits upstream.

## Configuration
- `CCIP_ARB_STATS_EN` defined:
  - Adds per-port 32-bit counters `stat_beats[N_PORTS]` and `stat_stall_cycles[N_PORTS]` as outputs.
  - `stat_stall_cycles` counts cycles where `req_valid & !req_ready`.
  - Both counters reset to 0 and saturate at `32'hFFFF_FFFF`.
- Not defined: the counters and their ports are absent, and the functional behaviour is identical.

## Test plan
- Ports 0 and 1 each hold continuous 1-line writes, with `N_PORTS` = 2 -> grants alternate 0,1,0,1, and `sTx_c1.valid` is high on every cycle from cycle 2 after reset release.
- Port 1 sends a 4-line burst (`cl_len` = 3) while port 0 requests from the burst's second cycle -> port 1's 4 beats are contiguous with `sop` = 1,0,0,0, then port 0 is granted on the next cycle.
- Almost-full rises after beat 2 of a 4-line burst -> beats 3 and 4 are still forwarded, no new `sop` is accepted while almost-full is high, and the first grant occurs the same cycle almost-full falls.
- The owner drops `req_valid` for 5 cycles mid 2-line burst while port 0 is valid -> `req_ready[0]` stays 0 throughout and the burst completes after the gap.
- Port 0 presents `sop = 0` in `ArbIdle` -> `error` = 1 and stays 1, the beat is consumed, and no `sTx_c1.valid` is produced for it.
- `reset_n` pulses low during beat 2 of a 4-line burst -> `sTx_c1.valid` = 0 and state is `ArbIdle`; a new `sop` beat from port 0 is accepted 1 cycle after release.
